registrador_de_saida_fifo: RTL and testbench
============================================

# registrador_de_saida_fifo

Parametrised output port for the SAP-1 datapath. Captures `bus_in` on the controller's `OPR_IN` strobe into a DEPTH-entry FIFO and delivers entries to an external consumer (display, UART bridge) over a valid/ready handshake. A holding register drives `OUT_BUS` with the last delivered word, so LEDs keep showing the most recent output. The CPU is never stalled: the block absorbs bursts of `OUT` instructions, and writes to a full buffer are dropped and flagged.

## Interface
- `WIDTH`, 8: word width of `bus_in`, FIFO entries, `OUT_BUS`, `out_data`.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `clear_n`  in  1  asynchronous, active-low reset.
- `OPR_IN`  in  1  write strobe from the control unit; push `bus_in` this cycle.
- `bus_in`  in  WIDTH  data from the W bus.
- `out_valid`  out  1  FIFO non-empty; `out_data` is meaningful.
- `out_ready`  in  1  consumer accepts `out_data` this cycle.
- `out_data`  out  WIDTH  FIFO head word.
- `OUT_BUS`  out  WIDTH  last word transferred (valid && ready).
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `count`  out  $clog2(DEPTH+1)  current occupancy.
- `overflow`  out  1  sticky drop flag (only with `REG_SAIDA_OVERFLOW_EN`).
- `overflow_clr`  in  1  synchronous clear of `overflow` (only with `REG_SAIDA_OVERFLOW_EN`).

## Operation
- Reset (`clear_n`=0, asynchronous): `OUT_BUS`=0, `count`=0, `empty`=1, `full`=0, `out_valid`=0, `out_data`=0, `overflow`=0, pointers=0.
- Push: `OPR_IN`=1 and (not full, or pop in the same cycle). The word is written at the write pointer.
- Pop: `out_valid` && `out_ready`. The head advances, and `OUT_BUS` <= `out_data` on the same edge.
- Push and pop in the same cycle: the count is unchanged. This is legal when full, and the push is accepted. When empty, only the push happens, because `out_valid`=0.
- Push while full without a pop: the word is dropped and the count and pointers are unchanged. With the macro, `overflow` is set.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full and empty are derived from `count`, not from pointer equality.
- `out_data` is the registered or memory head. When empty it holds the last head value, and consumers must qualify it with `out_valid`.
- `out_ready` asserted while `out_valid`=0 has no effect.
- `OUT_BUS` changes only on a pop or a reset.

## Timing
- Push to `out_valid`: 1 cycle. A word written at edge N is visible at the head after edge N, and can pop at edge N+1.
- Pop to `OUT_BUS` update: same edge as the handshake.
- `full`, `empty`, `count`, `out_valid` are registered or derived from registered `count`, and update on the edge of the push or pop.
- No combinational path from `out_ready` to `out_valid`. A combinational path from `out_ready` to the FIFO's internal accept logic is allowed.
- `clear_n` deasserted mid-burst: all queued words are lost, and the block restarts from the reset values.
- Throughput: one push and one pop per cycle, sustained.

## Configuration
- `REG_SAIDA_OVERFLOW_EN` defined:
  - `overflow` output and `overflow_clr` input exist.
  - `overflow` sets on the edge of a dropped push.
  - `overflow_clr` clears it; if both occur in the same cycle, set wins.
- Undefined: both ports are absent, and drops are silent.

## Structure
- Package `pacote_saida_pkg` holds `SAIDA_WIDTH_DEFAULT`=8 and `SAIDA_DEPTH_DEFAULT`=4.
- Sub-module `fifo_sincrona`: storage, pointers, count, full/empty.
- The top level adds the `OUT_BUS` holding register and the overflow logic.

## Test plan
- Reset with no activity: `OUT_BUS`=0x00, `empty`=1, `count`=0, `out_valid`=0.
- With `out_ready`=1, push 0x2A: `out_valid` goes high 1 cycle later. On the next edge `OUT_BUS`=0x2A and `empty`=1.
- With `out_ready`=0, push 0x01–0x04 (DEPTH=4): `full`=1. A fifth push of 0x05 is dropped and `overflow`=1. Then with `out_ready`=1, `OUT_BUS` shows 01, 02, 03, 04 on successive edges.
- Full FIFO, simultaneous push 0x55 and pop: `count` stays 4 and the push is accepted. 0x55 is the last word delivered, and `overflow` stays 0.
- Drive 10 pushes with a random `out_ready` pattern. Check pointer wrap-around: data order is preserved against a scoreboard.
- Assert `clear_n`=0 with 3 words queued: all outputs return to their reset values immediately, with no clock edge required.

Source files
------------

// File: rtl/pacote_saida_pkg.sv
// Shared defaults and width helpers for the SAP-1 output register block.
package pacote_saida_pkg;

  localparam int unsigned SAIDA_WIDTH_DEFAULT = 8;
  localparam int unsigned SAIDA_DEPTH_DEFAULT = 4;

  // Pointer width for a DEPTH-entry ring; at least one bit so the vector is legal.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy counter width: must represent 0..DEPTH inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/registrador_de_saida_fifo_fifo.sv
// fifo_sincrona: DEPTH-entry synchronous FIFO with a registered head word.
// Full/empty come from the occupancy count, never from pointer equality.
module fifo_sincrona
  import pacote_saida_pkg::*;
#(
  parameter int unsigned WIDTH = SAIDA_WIDTH_DEFAULT,
  parameter int unsigned DEPTH = SAIDA_DEPTH_DEFAULT
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          wr_req_i,
  input  logic [WIDTH-1:0]              wr_data_i,
  input  logic                          rd_ready_i,
  output logic                          rd_valid_o,
  output logic [WIDTH-1:0]              rd_data_o,
  output logic                          pop_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [cnt_width(DEPTH)-1:0]   count_o
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;

  logic full, empty, push, pop;
  logic head_from_push;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Handshakes: a pop frees a slot on the same edge, so a full FIFO still accepts a push.
  assign pop  = !empty && rd_ready_i;
  assign push = wr_req_i && (!full || pop);

  // The pushed word becomes the head when nothing else remains after this cycle's pop.
  assign head_from_push = push && (count_q == CW'(pop));

  // Next-state for pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + PW'(1);
    if (pop)  rptr_d = rptr_q + PW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Head register: tracks the new head, or keeps the last head when the FIFO drains.
  // Bypassing the write keeps push-to-valid at one cycle with no read-after-write hazard.
  always_comb begin
    head_d = head_q;
    if (count_d != '0) begin
      if (head_from_push) head_d = wr_data_i;
      else                head_d = mem_q[rptr_d];
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      head_q  <= head_d;
    end
  end

  // Storage array; contents are only observed through head_q, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= wr_data_i;
  end

  assign rd_valid_o = !empty;
  assign rd_data_o  = head_q;
  assign pop_o      = pop;
  assign full_o     = full;
  assign empty_o    = empty;
  assign count_o    = count_q;

endmodule

// File: rtl/registrador_de_saida_fifo.sv
// registrador_de_saida_fifo: SAP-1 output port. OPR_IN pushes bus_in into a
// FIFO drained over valid/ready; OUT_BUS holds the last delivered word.
// Optional feature macro: REG_SAIDA_OVERFLOW_EN adds the sticky overflow
// flag (overflow) and its synchronous clear (overflow_clr).
module registrador_de_saida_fifo
  import pacote_saida_pkg::*;
#(
  parameter int unsigned WIDTH = SAIDA_WIDTH_DEFAULT,
  parameter int unsigned DEPTH = SAIDA_DEPTH_DEFAULT
) (
  input  logic                        clock,
  input  logic                        clear_n,
  input  logic                        OPR_IN,
  input  logic [WIDTH-1:0]            bus_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [WIDTH-1:0]            OUT_BUS,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(DEPTH+1)-1:0]  count
`ifdef REG_SAIDA_OVERFLOW_EN
  ,
  output logic                        overflow,
  input  logic                        overflow_clr
`endif
);

  logic             pop;
  logic [WIDTH-1:0] out_bus_q, out_bus_d;

  fifo_sincrona #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i      (clock),
    .rst_ni     (clear_n),
    .wr_req_i   (OPR_IN),
    .wr_data_i  (bus_in),
    .rd_ready_i (out_ready),
    .rd_valid_o (out_valid),
    .rd_data_o  (out_data),
    .pop_o      (pop),
    .full_o     (full),
    .empty_o    (empty),
    .count_o    (count)
  );

  // Holding register captures the head on the same edge it is handed over.
  always_comb begin
    out_bus_d = out_bus_q;
    if (pop) out_bus_d = out_data;
  end

  // OUT_BUS register, cleared only by reset.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) out_bus_q <= '0;
    else          out_bus_q <= out_bus_d;
  end

  assign OUT_BUS = out_bus_q;

`ifdef REG_SAIDA_OVERFLOW_EN
  logic drop;
  logic overflow_q, overflow_d;

  // A write is lost only when full and no pop frees a slot in the same cycle.
  assign drop = OPR_IN && full && !pop;

  // Sticky flag: a drop in the same cycle as a clear takes priority.
  always_comb begin
    overflow_d = overflow_q;
    if (drop)              overflow_d = 1'b1;
    else if (overflow_clr) overflow_d = 1'b0;
  end

  // Overflow flag register.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) overflow_q <= 1'b0;
    else          overflow_q <= overflow_d;
  end

  assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_registrador_de_saida_fifo.sv
// Self-checking bench for registrador_de_saida_fifo (DEPTH=4, WIDTH=8).
module tb_registrador_de_saida_fifo;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned CW = $clog2(D + 1);
  localparam bit H = 1'b1;
  localparam bit L = 1'b0;

  logic          clock     = 1'b0;
  logic          clear_n   = 1'b0;
  logic          OPR_IN    = 1'b0;
  logic [W-1:0]  bus_in    = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [W-1:0]  OUT_BUS;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
`ifdef REG_SAIDA_OVERFLOW_EN
  logic          overflow;
  logic          overflow_clr = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  registrador_de_saida_fifo #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clock        (clock),
    .clear_n      (clear_n),
    .OPR_IN       (OPR_IN),
    .bus_in       (bus_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .OUT_BUS      (OUT_BUS),
    .full         (full),
    .empty        (empty),
    .count        (count)
`ifdef REG_SAIDA_OVERFLOW_EN
    ,
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic          opr;
    logic [W-1:0]  din;
    logic          rdy;
    logic          clr;
    logic          valid;
    logic [W-1:0]  data;
    logic [W-1:0]  obus;
    logic [CW-1:0] cnt;
    logic          fl;
    logic          em;
    logic          ovf;
  } vec_t;

  localparam int unsigned NV = 23;
  vec_t vt [NV];

  logic [W-1:0] q [$];
  logic [W-1:0] exp_word;
  logic         pop_m, push_m;
  int unsigned  k, delivered;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //         opr din    rdy clr  valid data   obus   cnt   full empty ovf
    vt[0]  = '{H, 8'h2A, H, L,   H, 8'h2A, 8'h00, 3'd1, L, L, L};
    vt[1]  = '{L, 8'h00, H, L,   L, 8'h2A, 8'h2A, 3'd0, L, H, L};
    vt[2]  = '{H, 8'h01, L, L,   H, 8'h01, 8'h2A, 3'd1, L, L, L};
    vt[3]  = '{H, 8'h02, L, L,   H, 8'h01, 8'h2A, 3'd2, L, L, L};
    vt[4]  = '{H, 8'h03, L, L,   H, 8'h01, 8'h2A, 3'd3, L, L, L};
    vt[5]  = '{H, 8'h04, L, L,   H, 8'h01, 8'h2A, 3'd4, H, L, L};
    vt[6]  = '{H, 8'h05, L, L,   H, 8'h01, 8'h2A, 3'd4, H, L, H};
    vt[7]  = '{L, 8'h00, H, H,   H, 8'h02, 8'h01, 3'd3, L, L, L};
    vt[8]  = '{L, 8'h00, H, L,   H, 8'h03, 8'h02, 3'd2, L, L, L};
    vt[9]  = '{L, 8'h00, H, L,   H, 8'h04, 8'h03, 3'd1, L, L, L};
    vt[10] = '{L, 8'h00, H, L,   L, 8'h04, 8'h04, 3'd0, L, H, L};
    vt[11] = '{H, 8'h10, L, L,   H, 8'h10, 8'h04, 3'd1, L, L, L};
    vt[12] = '{H, 8'h11, L, L,   H, 8'h10, 8'h04, 3'd2, L, L, L};
    vt[13] = '{H, 8'h12, L, L,   H, 8'h10, 8'h04, 3'd3, L, L, L};
    vt[14] = '{H, 8'h13, L, L,   H, 8'h10, 8'h04, 3'd4, H, L, L};
    vt[15] = '{H, 8'h55, H, L,   H, 8'h11, 8'h10, 3'd4, H, L, L};
    vt[16] = '{L, 8'h00, H, L,   H, 8'h12, 8'h11, 3'd3, L, L, L};
    vt[17] = '{L, 8'h00, H, L,   H, 8'h13, 8'h12, 3'd2, L, L, L};
    vt[18] = '{L, 8'h00, H, L,   H, 8'h55, 8'h13, 3'd1, L, L, L};
    vt[19] = '{L, 8'h00, H, L,   L, 8'h55, 8'h55, 3'd0, L, H, L};
    vt[20] = '{L, 8'h00, H, L,   L, 8'h55, 8'h55, 3'd0, L, H, L};
    vt[21] = '{H, 8'h77, H, L,   H, 8'h77, 8'h55, 3'd1, L, L, L};
    vt[22] = '{L, 8'h00, L, L,   H, 8'h77, 8'h55, 3'd1, L, L, L};

    // Reset and idle.
    repeat (2) @(posedge clock);
    #1;
    clear_n = 1'b1;
    step();
    chk("rst_out_bus", OUT_BUS, 8'h00);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
`ifdef REG_SAIDA_OVERFLOW_EN
    chk("rst_overflow", overflow, 1'b0);
`endif

    // Directed vector table.
    for (int unsigned i = 0; i < NV; i++) begin
      OPR_IN    = vt[i].opr;
      bus_in    = vt[i].din;
      out_ready = vt[i].rdy;
`ifdef REG_SAIDA_OVERFLOW_EN
      overflow_clr = vt[i].clr;
`endif
      step();
      chk($sformatf("v%0d_valid", i), out_valid, vt[i].valid);
      chk($sformatf("v%0d_data", i), out_data, vt[i].data);
      chk($sformatf("v%0d_out_bus", i), OUT_BUS, vt[i].obus);
      chk($sformatf("v%0d_count", i), count, vt[i].cnt);
      chk($sformatf("v%0d_full", i), full, vt[i].fl);
      chk($sformatf("v%0d_empty", i), empty, vt[i].em);
`ifdef REG_SAIDA_OVERFLOW_EN
      chk($sformatf("v%0d_overflow", i), overflow, vt[i].ovf);
`endif
    end
    OPR_IN    = 1'b0;
    out_ready = 1'b0;

`ifdef REG_SAIDA_OVERFLOW_EN
    // Fill to full (one word 0x77 already queued), then drop with a clear in the same cycle.
    OPR_IN = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      bus_in = 8'hA1 + 8'(i);
      step();
    end
    chk("ovf_fill_full", full, 1'b1);
    bus_in       = 8'hEE;
    overflow_clr = 1'b1;
    step();
    chk("ovf_set_wins", overflow, 1'b1);
    chk("ovf_drop_count", count, 4);
    OPR_IN = 1'b0;
    step();
    chk("ovf_clear", overflow, 1'b0);
    overflow_clr = 1'b0;
`endif

    // Drain whatever is queued.
    out_ready = 1'b1;
    for (int unsigned i = 0; i < 8 && !empty; i++) step();
    chk("drain_empty", empty, 1'b1);
`ifdef REG_SAIDA_OVERFLOW_EN
    chk("drain_out_bus", OUT_BUS, 8'hA3);
`else
    chk("drain_out_bus", OUT_BUS, 8'h77);
`endif

    // Random out_ready with 10 words through a 4-deep ring, checked against a queue model.
    k = 0;
    delivered = 0;
    for (int unsigned cyc = 0; cyc < 200 && delivered < 10; cyc++) begin
      OPR_IN    = (k < 10);
      bus_in    = 8'(8'hC0 + k);
      out_ready = 1'($urandom_range(0, 1));
      pop_m  = (q.size() != 0) && out_ready;
      push_m = OPR_IN && ((q.size() < D) || pop_m);
      step();
      if (pop_m) begin
        exp_word = q.pop_front();
        chk("sb_out_bus", OUT_BUS, exp_word);
        delivered++;
      end
      if (push_m) begin
        q.push_back(bus_in);
        k++;
      end
      chk("sb_count", count, q.size());
      if (q.size() != 0) chk("sb_head", out_data, q[0]);
    end
    chk("sb_delivered", delivered, 10);
    OPR_IN    = 1'b0;
    out_ready = 1'b0;

    // Asynchronous reset with three words queued.
    OPR_IN = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      bus_in = 8'hD1 + 8'(i);
      step();
    end
    OPR_IN = 1'b0;
    chk("pre_rst_count", count, 3);
    #2;
    clear_n = 1'b0;
    #1;
    chk("arst_out_bus", OUT_BUS, 8'h00);
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1'b1);
    chk("arst_full", full, 1'b0);
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_out_data", out_data, 8'h00);
`ifdef REG_SAIDA_OVERFLOW_EN
    chk("arst_overflow", overflow, 1'b0);
`endif
    step();
    clear_n = 1'b1;
    step();
    chk("post_rst_count", count, 0);
    chk("post_rst_valid", out_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
